// File: rtl/pixel_plotter_pkg.sv
// Shared types and defaults for the pixel plotter: FSM state encoding, coordinate type,
// framebuffer/FIFO default sizes and a saturating counter helper.
package pixel_plotter_pkg;

    localparam int DEF_FB_W       = 64;
    localparam int DEF_FB_H       = 64;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef logic signed [31:0] coord_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pixel_plotter_fifo.sv
// coord_fifo: synchronous FIFO of precomputed pixel addresses with full/empty flags.
// Storage is unreset; only pointers and occupancy are cleared.
module coord_fifo
    import pixel_plotter_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             _clock,
    input  logic             _reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge _clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (!push_ok && pop_ok) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/pixel_plotter.sv
// Pixel plotter: turns (x, y) pairs into framebuffer writes of a per-frame colour.
// Define PIXEL_PLOTTER_CLIP_EN to discard off-screen pairs; otherwise coordinates wrap.
module pixel_plotter
    import pixel_plotter_pkg::*;
#(
    parameter int FB_W       = DEF_FB_W,
    parameter int FB_H       = DEF_FB_H,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int ADDR_W     = 12
) (
    input  logic               _clock,
    input  logic               _reset,
    input  logic               _start,
    input  logic [7:0]         _color,
    input  logic signed [31:0] _in0,
    input  logic signed [31:0] _in1,
    input  logic               _in_valid,
    output logic               _in_ready,
    input  logic               _in_done,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [7:0]         mem_wdata,
    output logic               mem_we,
    input  logic               mem_ready,
    output logic [15:0]        plotted,
    output logic [15:0]        clipped,
    output logic               _done
);

    localparam int XW = $clog2(FB_W);
    localparam int YW = $clog2(FB_H);

    state_e            state_q;
    state_e            state_d;
    logic [7:0]        color_q;
    logic              start_frame;
    logic              accept;
    logic              in_clip;
    logic [ADDR_W-1:0] in_addr;
    logic              load;
    logic              bypass;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W-1:0] fifo_rdata;

    assign start_frame = (state_q == IDLE) & _start;
    assign _in_ready   = (state_q == RUN) & ~fifo_full;
    assign accept      = _in_valid & _in_ready;
    assign _done       = (state_q == DONE);
    assign in_addr     = ADDR_W'({_in1[YW-1:0], _in0[XW-1:0]});

`ifdef PIXEL_PLOTTER_CLIP_EN
    assign in_clip = (_in0 < 0) | (_in0 >= FB_W) | (_in1 < 0) | (_in1 >= FB_H);
`else
    logic unused_coord_bits;
    assign in_clip           = 1'b0;
    assign unused_coord_bits = ^{_in0[31:XW], _in1[31:YW]};
`endif

    // An empty FIFO lets an accepted pair go straight to the output register,
    // so the write can appear the cycle after acceptance.
    assign load      = ~mem_we | mem_ready;
    assign bypass    = load & fifo_empty & accept & ~in_clip;
    assign fifo_push = accept & ~in_clip & ~bypass;
    assign fifo_pop  = load & ~fifo_empty;

    coord_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        ._clock (_clock),
        ._reset (_reset),
        .clear  (start_frame),
        .push   (fifo_push),
        .wdata  (in_addr),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (_start) state_d = RUN;
            RUN:     if (_in_done) state_d = DRAIN;
            DRAIN:   if (fifo_empty && !mem_we) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            state_q <= IDLE;
            color_q <= 8'd0;
        end else begin
            state_q <= state_d;
            if (start_frame) color_q <= _color;
        end
    end

    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
        end else if (start_frame) begin
            mem_we <= 1'b0;
        end else if (load) begin
            if (fifo_pop) begin
                mem_we    <= 1'b1;
                mem_addr  <= fifo_rdata;
                mem_wdata <= color_q;
            end else if (bypass) begin
                mem_we    <= 1'b1;
                mem_addr  <= in_addr;
                mem_wdata <= color_q;
            end else begin
                mem_we <= 1'b0;
            end
        end
    end

    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            plotted <= 16'd0;
            clipped <= 16'd0;
        end else if (start_frame) begin
            plotted <= 16'd0;
            clipped <= 16'd0;
        end else begin
            if (mem_we && mem_ready) plotted <= sat_inc(plotted);
            if (accept && in_clip)   clipped <= sat_inc(clipped);
        end
    end

endmodule
